prog_loader: RTL and testbench

- Upstream boot stage for the multicycle accumulator CPU.
- Receives a byte stream over a valid/ready handshake and assembles big-endian 16-bit words.
- Writes the words into the shared instruction/data memory at consecutive addresses.
- Holds the CPU in reset until the load completes. A length error leaves the CPU in reset.

---
 rtl/prog_loader.sv | 126 ++++++++++++
 tb/tb_prog_loader.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/prog_loader.sv
// Boot loader: turns a length-prefixed big-endian byte stream into 16-bit memory
// writes at consecutive addresses, holding the CPU in reset until the load succeeds.
module prog_loader #(
  parameter int ADDR_W    = 12,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              load_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  output logic              mem_write,
  output logic              cpu_rst,
  output logic              done,
  output logic              err
);

  localparam logic [2:0] CNT_HI = 3'd0;
  localparam logic [2:0] CNT_LO = 3'd1;
  localparam logic [2:0] DAT_HI = 3'd2;
  localparam logic [2:0] DAT_LO = 3'd3;
  localparam logic [2:0] WRITE  = 3'd4;
  localparam logic [2:0] DONE   = 3'd5;
  localparam logic [2:0] ERR    = 3'd6;

  // Words available between BASE_ADDR and the top of memory; 17 bits so that a
  // full 16-bit address space still fits.
  localparam logic [16:0]       LIMIT = 17'((64'd1 << ADDR_W) - 64'(BASE_ADDR));
  localparam logic [ADDR_W-1:0] BASE  = ADDR_W'(BASE_ADDR);

  logic [2:0]  state;
  logic [15:0] count;
  logic [15:0] word_count;
  logic        accept;

  // Only the four byte-collecting states take stream data.
  always_comb begin
    in_ready = 1'b0;
    case (state)
      CNT_HI, CNT_LO, DAT_HI, DAT_LO: in_ready = 1'b1;
      default:                        in_ready = 1'b0;
    endcase
  end

  assign accept     = in_valid && in_ready;
  assign word_count = {count[15:8], in_data};

  // Loader FSM with registered memory-port and CPU-control outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= CNT_HI;
      count     <= 16'd0;
      mem_addr  <= BASE;
      mem_wdata <= 16'd0;
      mem_write <= 1'b0;
      cpu_rst   <= 1'b1;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      mem_write <= 1'b0;
      case (state)
        CNT_HI: begin
          if (accept) begin
            count[15:8] <= in_data;
            state       <= CNT_LO;
          end
        end
        CNT_LO: begin
          if (accept) begin
            count[7:0] <= in_data;
            if (word_count == 16'd0) begin
              state   <= DONE;
              done    <= 1'b1;
              cpu_rst <= 1'b0;
            end else if ({1'b0, word_count} > LIMIT) begin
              state <= ERR;
              err   <= 1'b1;
            end else begin
              state <= DAT_HI;
            end
          end
        end
        DAT_HI: begin
          if (accept) begin
            mem_wdata[15:8] <= in_data;
            state           <= DAT_LO;
          end
        end
        DAT_LO: begin
          if (accept) begin
            mem_wdata[7:0] <= in_data;
            mem_write      <= 1'b1;
            state          <= WRITE;
          end
        end
        WRITE: begin
          mem_addr <= mem_addr + ADDR_W'(1);
          count    <= count - 16'd1;
          // count still holds the pre-decrement value here.
          if (count == 16'd1) begin
            state   <= DONE;
            done    <= 1'b1;
            cpu_rst <= 1'b0;
          end else begin
            state <= DAT_HI;
          end
        end
        DONE, ERR: begin
          if (load_req) begin
            state    <= CNT_HI;
            cpu_rst  <= 1'b1;
            done     <= 1'b0;
            err      <= 1'b0;
            mem_addr <= BASE;
            count    <= 16'd0;
          end
        end
        default: state <= CNT_HI;
      endcase
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: a default instance (ADDR_W=12, BASE_ADDR=0) and a
// small instance (ADDR_W=4, BASE_ADDR=14); memory writes are checked against queues.
module tb_prog_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        load_req;
  logic        sel;
  logic        a_valid, b_valid, a_load, b_load;

  logic        a_in_ready, a_mem_write, a_cpu_rst, a_done, a_err;
  logic [11:0] a_mem_addr;
  logic [15:0] a_mem_wdata;
  logic        b_in_ready, b_mem_write, b_cpu_rst, b_done, b_err;
  logic [3:0]  b_mem_addr;
  logic [15:0] b_mem_wdata;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int wa     = 0;
  int wb     = 0;
  int c0;
  logic [31:0] qa[$];
  logic [31:0] qb[$];

  assign a_valid = in_valid & ~sel;
  assign b_valid = in_valid & sel;
  assign a_load  = load_req & ~sel;
  assign b_load  = load_req & sel;

  prog_loader #(.ADDR_W(12), .BASE_ADDR(0)) dut_a (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(a_valid), .in_ready(a_in_ready),
    .load_req(a_load), .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata),
    .mem_write(a_mem_write), .cpu_rst(a_cpu_rst), .done(a_done), .err(a_err)
  );

  prog_loader #(.ADDR_W(4), .BASE_ADDR(14)) dut_b (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(b_valid), .in_ready(b_in_ready),
    .load_req(b_load), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
    .mem_write(b_mem_write), .cpu_rst(b_cpu_rst), .done(b_done), .err(b_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Scoreboard: each write strobe pops the next expected {addr, data}.
  always @(negedge clk) begin
    if (a_mem_write === 1'b1) begin
      wa++;
      if (qa.size() == 0) chk("a_unexpected_write", {4'd0, a_mem_addr, a_mem_wdata}, 32'hFFFF_FFFF);
      else chk("a_write", {4'd0, a_mem_addr, a_mem_wdata}, qa.pop_front());
    end
    if (b_mem_write === 1'b1) begin
      wb++;
      if (qb.size() == 0) chk("b_unexpected_write", {12'd0, b_mem_addr, b_mem_wdata}, 32'hFFFF_FFFF);
      else chk("b_write", {12'd0, b_mem_addr, b_mem_wdata}, qb.pop_front());
    end
  end

  // Present a byte from the falling edge; returns 1 time unit after the accepting edge.
  task automatic send(input logic [7:0] b);
    int n = 0;
    @(negedge clk);
    in_data  = b;
    in_valid = 1'b1;
    while (((sel ? b_in_ready : a_in_ready) !== 1'b1) && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) chk("send_timeout", 32'(n), 32'd0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic restart();
    @(negedge clk);
    load_req = 1'b1;
    @(posedge clk);
    #1;
    load_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; sel = 1'b0; in_valid = 1'b0; load_req = 1'b0; in_data = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", 32'(a_in_ready), 32'd1);
    chk("rst_cpu_rst", 32'(a_cpu_rst), 32'd1);
    chk("rst_done_err", {30'd0, a_done, a_err}, 32'd0);
    chk("rst_mem", {3'd0, a_mem_write, a_mem_addr, a_mem_wdata}, 32'd0);
    chk("rst_b_addr", 32'(b_mem_addr), 32'd14);
    @(negedge clk) rst = 1'b0;

    // Two-word load with in_valid effectively held high.
    send(8'h00); c0 = cyc;
    send(8'h02); send(8'h12);
    qa.push_back({4'd0, 12'd0, 16'h1234});
    send(8'h34);
    chk("t1_strobe", 32'(a_mem_write), 32'd1);
    send(8'hAB);
    qa.push_back({4'd0, 12'd1, 16'hABCD});
    send(8'hCD);
    chk("t1_not_done_yet", 32'(a_done), 32'd0);
    @(posedge clk); #1;
    chk("t1_done", {30'd0, a_done, a_cpu_rst}, 32'd2);
    chk("t1_done_latency", 32'(cyc - c0), 32'd7);
    chk("t1_writes", 32'(wa), 32'd2);
    chk("t1_addr_after", 32'(a_mem_addr), 32'd2);

    // DONE ignores bytes, including one coinciding with load_req.
    @(negedge clk); in_data = 8'hFF; in_valid = 1'b1;
    @(posedge clk); #1;
    chk("done_ignores", {30'd0, a_in_ready, a_done}, 32'd1);
    @(negedge clk); load_req = 1'b1;
    @(posedge clk); #1;
    load_req = 1'b0; in_valid = 1'b0;
    chk("restart_ctrl", {29'd0, a_cpu_rst, a_done, a_err}, 32'd4);
    chk("restart_addr", 32'(a_mem_addr), 32'd0);

    // Restart stream; load_req mid-load must be ignored.
    send(8'h00); send(8'h01);
    qa.push_back({4'd0, 12'd0, 16'h55AA});
    send(8'h55);
    @(negedge clk); load_req = 1'b1;
    @(negedge clk); load_req = 1'b0;
    send(8'hAA);
    @(posedge clk); #1;
    chk("t2_done", {30'd0, a_done, a_cpu_rst}, 32'd2);
    chk("t2_addr", 32'(a_mem_addr), 32'd1);
    chk("t2_writes", 32'(wa), 32'd3);

    // Gap in the middle of a word, then a byte held through the WRITE cycle.
    restart();
    send(8'h00); send(8'h03); send(8'h11);
    repeat (3) @(negedge clk);
    chk("gap_no_write", 32'(wa), 32'd3);
    qa.push_back({4'd0, 12'd0, 16'h1122});
    send(8'h22);
    in_data = 8'h33; in_valid = 1'b1;
    chk("bp_ready_low", 32'(a_in_ready), 32'd0);
    @(posedge clk); #1;
    chk("bp_not_taken", 32'(a_mem_wdata), 32'h1122);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("bp_taken", 32'(a_mem_wdata), 32'h3322);
    qa.push_back({4'd0, 12'd1, 16'h3344});
    send(8'h44);
    send(8'h55);
    qa.push_back({4'd0, 12'd2, 16'h5566});
    send(8'h66);
    @(posedge clk); #1;
    chk("t3_done", 32'(a_done), 32'd1);
    chk("t3_addr", 32'(a_mem_addr), 32'd3);
    chk("t3_writes", 32'(wa), 32'd6);

    // Zero length goes straight to DONE.
    restart();
    send(8'h00); send(8'h00);
    chk("zero_done", {30'd0, a_done, a_cpu_rst}, 32'd2);
    chk("zero_no_write", {31'd0, a_mem_write}, 32'd0);
    chk("zero_writes", 32'(wa), 32'd6);

    // Asynchronous reset while collecting the second word.
    restart();
    send(8'h00); send(8'h02); send(8'hAA);
    qa.push_back({4'd0, 12'd0, 16'hAABB});
    send(8'hBB); send(8'hCC);
    #1 rst = 1'b1;
    #1;
    chk("arst_mem", {3'd0, a_mem_write, a_mem_addr, a_mem_wdata}, 32'd0);
    chk("arst_ctrl", {28'd0, a_in_ready, a_cpu_rst, a_done, a_err}, 32'hC);
    chk("arst_writes", 32'(wa), 32'd7);
    @(negedge clk) rst = 1'b0;
    send(8'h00); send(8'h01);
    qa.push_back({4'd0, 12'd0, 16'hBEEF});
    send(8'hBE); send(8'hEF);
    @(posedge clk); #1;
    chk("t4_done", {30'd0, a_done, a_cpu_rst}, 32'd2);
    chk("t4_writes", 32'(wa), 32'd8);

    // Small memory: 3 words from base 14 overflow; 2 words fit exactly.
    sel = 1'b1;
    send(8'h00); send(8'h03);
    chk("len_err", {29'd0, b_err, b_cpu_rst, b_in_ready}, 32'd6);
    @(negedge clk); in_data = 8'h77; in_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("err_holds", {29'd0, b_err, b_cpu_rst, b_in_ready}, 32'd6);
    chk("err_no_write", 32'(wb), 32'd0);
    restart();
    chk("err_restart", {28'd0, b_mem_addr}, 32'd14);
    chk("err_clear", 32'(b_err), 32'd0);
    send(8'h00); send(8'h02); send(8'h01);
    qb.push_back({12'd0, 4'd14, 16'h0102});
    send(8'h02); send(8'h03);
    qb.push_back({12'd0, 4'd15, 16'h0304});
    send(8'h04);
    @(posedge clk); #1;
    chk("fit_done", {29'd0, b_done, b_err, b_cpu_rst}, 32'd4);
    chk("fit_writes", 32'(wb), 32'd2);

    chk("qa_empty", 32'(qa.size()), 32'd0);
    chk("qb_empty", 32'(qb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
